// File: rtl/sata_host_oob_ctrl.sv
// rtl/sata_host_oob_ctrl.sv - host-side SATA OOB sequencer: COMRESET/COMWAKE, dialtone, ALIGN handshake, then link passthrough
module sata_host_oob_ctrl #(
  parameter int INIT_TIMEOUT   = 1000,
  parameter int ALIGN_TIMEOUT  = 2000,
  parameter int NONALIGN_COUNT = 3,
  parameter int IDLE_LOSS      = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_platform_ready,
  input  logic [31:0] i_link_tx_dout,
  input  logic        i_link_tx_is_k,
  output logic [31:0] o_tx_dout,
  output logic        o_tx_is_k,
  output logic        o_tx_elec_idle,
  output logic        o_tx_comm_reset,
  output logic        o_tx_comm_wake,
  input  logic [31:0] i_rx_din,
  input  logic [3:0]  i_rx_is_k,
  input  logic        i_rx_is_elec_idle,
  input  logic        i_rx_byte_is_aligned,
  input  logic        i_comm_init_detect,
  input  logic        i_comm_wake_detect,
  output logic        o_phy_ready,
  output logic [3:0]  o_oob_state,
  output logic [7:0]  o_retry_count
);

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] DIALTONE   = 32'h4A4A4A4A;
  localparam logic [31:0] INIT_LOAD  = 32'(INIT_TIMEOUT);
  localparam logic [31:0] ALIGN_LOAD = 32'(ALIGN_TIMEOUT);
  localparam logic [7:0]  NA_MAX     = 8'(NONALIGN_COUNT);
  localparam logic [15:0] IDLE_MAX   = 16'(IDLE_LOSS);

  typedef enum logic [3:0] {
    S_IDLE = 4'h0, S_SEND_RESET = 4'h1, S_WAIT_INIT = 4'h2, S_WAIT_NO_INIT = 4'h3,
    S_SEND_WAKE = 4'h4, S_WAIT_WAKE = 4'h5, S_WAIT_NO_WAKE = 4'h6, S_WAIT_ALIGN = 4'h7,
    S_SEND_ALIGN = 4'h8, S_READY = 4'h9, S_RETRY = 4'hA
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_timer;
  logic [7:0]  r_na_cnt;
  logic [15:0] r_idle_cnt;
  logic [7:0]  r_retry;
  logic [31:0] r_tx_dout;
  logic        r_tx_is_k, r_tx_elec_idle, r_comm_reset, r_comm_wake;

  logic w_align_det, w_nonalign_det, w_timeout, w_na_done, w_idle_lost;
  assign w_align_det    = (i_rx_is_k != 4'b0) && (i_rx_din == PRIM_ALIGN) && i_rx_byte_is_aligned;
  assign w_nonalign_det = i_rx_is_k[0] && (i_rx_din != PRIM_ALIGN) && i_rx_byte_is_aligned;
  assign w_timeout      = (r_timer == 32'd0);
  assign w_na_done      = w_nonalign_det && ((r_na_cnt + 8'd1) == NA_MAX);
  assign w_idle_lost    = i_rx_is_elec_idle && ((r_idle_cnt + 16'd1) == IDLE_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Detects are tested before timeouts so a same-cycle detect always wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:         if (i_platform_ready) w_next = S_SEND_RESET;
      S_SEND_RESET:   w_next = S_WAIT_INIT;
      S_WAIT_INIT:    if (i_comm_init_detect) w_next = S_WAIT_NO_INIT;
                      else if (w_timeout)     w_next = S_RETRY;
      S_WAIT_NO_INIT: if (!i_comm_init_detect) w_next = S_SEND_WAKE;
      S_SEND_WAKE:    w_next = S_WAIT_WAKE;
      S_WAIT_WAKE:    if (i_comm_wake_detect) w_next = S_WAIT_NO_WAKE;
                      else if (w_timeout)     w_next = S_RETRY;
      S_WAIT_NO_WAKE: if (!i_comm_wake_detect) w_next = S_WAIT_ALIGN;
      S_WAIT_ALIGN:   if (w_align_det)    w_next = S_SEND_ALIGN;
                      else if (w_timeout) w_next = S_RETRY;
      S_SEND_ALIGN:   if (w_na_done)      w_next = S_READY;
                      else if (w_timeout) w_next = S_RETRY;
      S_READY:        if (i_comm_init_detect || w_idle_lost) w_next = S_RETRY;
      S_RETRY:        w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_phy_ready = (r_state == S_READY);
    o_oob_state = r_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer        <= 32'd0;
      r_na_cnt       <= 8'd0;
      r_idle_cnt     <= 16'd0;
      r_retry        <= 8'd0;
      r_tx_dout      <= 32'd0;
      r_tx_is_k      <= 1'b0;
      r_tx_elec_idle <= 1'b1;
      r_comm_reset   <= 1'b0;
      r_comm_wake    <= 1'b0;
    end else begin
      r_comm_reset <= 1'b0;
      r_comm_wake  <= 1'b0;
      if (r_timer != 32'd0) r_timer <= r_timer - 32'd1;
      case (r_state)
        S_IDLE:       r_tx_elec_idle <= 1'b1;
        S_SEND_RESET: begin r_comm_reset <= 1'b1; r_timer <= INIT_LOAD; end
        S_SEND_WAKE:  begin r_comm_wake  <= 1'b1; r_timer <= INIT_LOAD; end
        S_WAIT_NO_WAKE: if (w_next == S_WAIT_ALIGN) begin
          r_tx_elec_idle <= 1'b0;
          r_tx_dout      <= DIALTONE;
          r_tx_is_k      <= 1'b0;
          r_timer        <= ALIGN_LOAD;
        end
        S_WAIT_ALIGN: if (w_next == S_SEND_ALIGN) begin
          r_tx_dout <= PRIM_ALIGN;
          r_tx_is_k <= 1'b1;
          r_na_cnt  <= 8'd0;
          r_timer   <= ALIGN_LOAD;
        end
        // Holding the idle counter clear here guarantees READY starts at zero.
        S_SEND_ALIGN: begin
          r_na_cnt   <= w_nonalign_det ? r_na_cnt + 8'd1 : 8'd0;
          r_idle_cnt <= 16'd0;
        end
        S_READY: begin
          r_tx_dout  <= i_link_tx_dout;
          r_tx_is_k  <= i_link_tx_is_k;
          r_idle_cnt <= i_rx_is_elec_idle ? r_idle_cnt + 16'd1 : 16'd0;
        end
        S_RETRY: begin
          if (r_retry != 8'hFF) r_retry <= r_retry + 8'd1;
          r_tx_elec_idle <= 1'b1;
          r_tx_dout      <= 32'd0;
          r_tx_is_k      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_tx_dout       = r_tx_dout;
  assign o_tx_is_k       = r_tx_is_k;
  assign o_tx_elec_idle  = r_tx_elec_idle;
  assign o_tx_comm_reset = r_comm_reset;
  assign o_tx_comm_wake  = r_comm_wake;
  assign o_retry_count   = r_retry;

endmodule

// File: tb/tb_sata_host_oob_ctrl.sv
// tb/tb_sata_host_oob_ctrl.sv - directed self-checking bench for sata_host_oob_ctrl
module tb_sata_host_oob_ctrl;

  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] DIAL  = 32'h4A4A4A4A;
  localparam logic [31:0] SYNC  = 32'hB5B5957C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        platform_ready = 1'b0;
  logic [31:0] link_tx_dout = 32'd0;
  logic        link_tx_is_k = 1'b0;
  logic [31:0] tx_dout;
  logic        tx_is_k, tx_elec_idle, tx_comm_reset, tx_comm_wake;
  logic [31:0] rx_din = 32'd0;
  logic [3:0]  rx_is_k = 4'd0;
  logic        rx_is_elec_idle = 1'b0;
  logic        rx_byte_is_aligned = 1'b0;
  logic        comm_init_detect = 1'b0;
  logic        comm_wake_detect = 1'b0;
  logic        phy_ready;
  logic [3:0]  oob_state;
  logic [7:0]  retry_count;

  int n_vec  = 0;
  int n_fail = 0;
  int n, bad;

  sata_host_oob_ctrl #(.INIT_TIMEOUT(16), .ALIGN_TIMEOUT(24), .NONALIGN_COUNT(3), .IDLE_LOSS(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_platform_ready(platform_ready),
    .i_link_tx_dout(link_tx_dout), .i_link_tx_is_k(link_tx_is_k),
    .o_tx_dout(tx_dout), .o_tx_is_k(tx_is_k), .o_tx_elec_idle(tx_elec_idle),
    .o_tx_comm_reset(tx_comm_reset), .o_tx_comm_wake(tx_comm_wake),
    .i_rx_din(rx_din), .i_rx_is_k(rx_is_k), .i_rx_is_elec_idle(rx_is_elec_idle),
    .i_rx_byte_is_aligned(rx_byte_is_aligned),
    .i_comm_init_detect(comm_init_detect), .i_comm_wake_detect(comm_wake_detect),
    .o_phy_ready(phy_ready), .o_oob_state(oob_state), .o_retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From WAIT_INIT (COMRESET pulse just seen) through to WAIT_ALIGN with dialtone on the line.
  task automatic to_dialtone;
    comm_init_detect = 1'b1; tick;
    comm_init_detect = 1'b0; tick;
    tick;
    comm_wake_detect = 1'b1; tick;
    comm_wake_detect = 1'b0; tick;
  endtask

  task automatic rx_prim(input logic [31:0] w);
    rx_din = w; rx_is_k = 4'b0001; rx_byte_is_aligned = 1'b1;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick; tick;
    check("rst_state", 32'(oob_state), 32'h0);
    check("rst_elec_idle", 32'(tx_elec_idle), 32'h1);
    check("rst_dout", tx_dout, 32'h0);
    check("rst_retry", 32'(retry_count), 32'h0);
    check("rst_ready", 32'(phy_ready), 32'h0);

    // Nominal bring-up with a broken non-ALIGN streak
    rst = 1'b0; platform_ready = 1'b1;
    tick; check("send_reset", 32'(oob_state), 32'h1);
    tick; check("wait_init", 32'(oob_state), 32'h2);
    check("comreset_pulse", 32'(tx_comm_reset), 32'h1);
    comm_init_detect = 1'b1; tick;
    check("wait_no_init", 32'(oob_state), 32'h3);
    check("comreset_one_cycle", 32'(tx_comm_reset), 32'h0);
    comm_init_detect = 1'b0; tick;
    check("send_wake", 32'(oob_state), 32'h4);
    tick; check("comwake_pulse", 32'(tx_comm_wake), 32'h1);
    comm_wake_detect = 1'b1; tick;
    check("wait_no_wake", 32'(oob_state), 32'h6);
    check("comwake_one_cycle", 32'(tx_comm_wake), 32'h0);
    comm_wake_detect = 1'b0; tick;
    check("wait_align", 32'(oob_state), 32'h7);
    check("dialtone", tx_dout, DIAL);
    check("dialtone_k", 32'(tx_is_k), 32'h0);
    check("dialtone_active", 32'(tx_elec_idle), 32'h0);
    rx_prim(SYNC);
    check("sync_not_align", 32'(oob_state), 32'h7);
    rx_prim(ALIGN);
    check("send_align", 32'(oob_state), 32'h8);
    check("align_dout", tx_dout, ALIGN);
    check("align_k", 32'(tx_is_k), 32'h1);
    rx_prim(SYNC); rx_prim(SYNC); rx_prim(ALIGN); rx_prim(SYNC); rx_prim(SYNC);
    check("streak_broken", 32'(phy_ready), 32'h0);
    rx_prim(SYNC);
    check("ready_state", 32'(oob_state), 32'h9);
    check("phy_ready", 32'(phy_ready), 32'h1);

    // READY passthrough and elec-idle loss
    rx_din = 32'd0; rx_is_k = 4'd0;
    link_tx_dout = 32'h7C95B5B5; link_tx_is_k = 1'b1;
    tick;
    check("pass_dout", tx_dout, 32'h7C95B5B5);
    check("pass_k", 32'(tx_is_k), 32'h1);
    rx_is_elec_idle = 1'b1;
    repeat (63) tick;
    rx_is_elec_idle = 1'b0; tick;
    check("idle63_stays", 32'(oob_state), 32'h9);
    rx_is_elec_idle = 1'b1;
    repeat (63) tick;
    check("idle63_again", 32'(oob_state), 32'h9);
    tick;
    check("idle64_retry", 32'(oob_state), 32'hA);
    rx_is_elec_idle = 1'b0; tick;
    check("retry_to_idle", 32'(oob_state), 32'h0);
    check("retry_count1", 32'(retry_count), 32'h1);
    check("retry_elec_idle", 32'(tx_elec_idle), 32'h1);
    check("retry_dout", tx_dout, 32'h0);

    // Silent device: COMRESET every INIT_TIMEOUT+4 cycles
    tick; tick;
    check("reissue_pulse", 32'(tx_comm_reset), 32'h1);
    for (int r = 2; r <= 3; r++) begin
      n = 0; bad = 0;
      for (int i = 0; i < 100; i++) begin
        tick; n++;
        if (phy_ready) bad++;
        if (tx_comm_reset) break;
      end
      check("cominit_period", 32'(n), 32'd20);
      check("cominit_retry", 32'(retry_count), 32'(r));
      check("cominit_not_ready", 32'(bad), 32'd0);
    end

    // Device never sends ALIGN
    to_dialtone;
    check("dial_again", 32'(oob_state), 32'h7);
    rx_din = SYNC; rx_is_k = 4'b0001; rx_byte_is_aligned = 1'b1;
    n = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick; n++;
      if (tx_dout !== DIAL) bad++;
      if (oob_state == 4'hA) break;
    end
    check("align_timeout", 32'(n), 32'd25);
    check("no_align_sent", 32'(bad), 32'd0);
    tick;
    check("retry_count4", 32'(retry_count), 32'h4);

    // Reset while in SEND_ALIGN
    tick; tick;
    to_dialtone;
    rx_prim(ALIGN);
    check("pre_rst_state", 32'(oob_state), 32'h8);
    rst = 1'b1; tick;
    check("mid_rst_state", 32'(oob_state), 32'h0);
    check("mid_rst_dout", tx_dout, 32'h0);
    check("mid_rst_k", 32'(tx_is_k), 32'h0);
    check("mid_rst_idle", 32'(tx_elec_idle), 32'h1);
    check("mid_rst_retry", 32'(retry_count), 32'h0);
    check("mid_rst_ready", 32'(phy_ready), 32'h0);
    rst = 1'b0; platform_ready = 1'b0; tick;
    check("hold_idle", 32'(oob_state), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
